// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helper functions and core state encoding.
// Pure definitions: no latency, no flow control.
package sha256_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, DONE} state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word sliding message schedule; wt is W[t] the cycle after load, then advances one word per shift.
// No backpressure: the caller owns load/shift timing.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         load,
    input  logic [511:0] block,
    input  logic         shift,
    output logic [31:0]  wt
);

    logic [31:0] w_q [16];
    logic [31:0] w_new;

    // With w_q[0] = W[t], this yields W[t+16]; extra words computed past t=47 are never consumed.
    assign w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    assign wt    = w_q[0];

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= block[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                w_q[i] <= w_q[i+1];
            end
            w_q[15] <= w_new;
        end
    end

endmodule

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256, one round per clock; done pulses 1+66*NBLK cycles after start is accepted.
// start is only honoured in IDLE; requests while busy or in DONE are dropped, not queued.
module sha256_iter_core
    import sha256_pkg::*;
#(
    parameter int MSG_SIZE = 120
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MSG_SIZE-1:0] message,
    output logic                busy,
    output logic                done,
    output logic [255:0]        hashed
);

    localparam int NBLK = (MSG_SIZE + 65 + 511) / 512;
    localparam int PADW = NBLK * 512;

    state_t          state_q, state_d;
    logic [PADW-1:0] pad, pad_q;
    logic [31:0]     hreg_q [8];
    logic [31:0]     work_q [8];
    logic [2:0]      blk_q;
    logic [5:0]      t_q;
    logic [255:0]    hashed_q;
    logic            done_q;
    logic [31:0]     wt, t1, t2;
    logic            last_blk;

    // Built with a shift so that a zero-length zero field (MSG_SIZE % 512 == 447) stays legal.
    assign pad = (PADW'({message, 1'b1}) << (PADW - MSG_SIZE - 1)) | PADW'(64'(MSG_SIZE));

    assign last_blk = (blk_q == 3'(NBLK - 1));

    assign t1 = work_q[7] + bsig1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6]) + K[t_q] + wt;
    assign t2 = bsig0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);

    sha256_msg_sched u_sched (
        .clk   (clk),
        .load  (state_q == LOAD),
        .block (pad_q[PADW-1 -: 512]),
        .shift (state_q == ROUND),
        .wt    (wt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = ROUND;
            ROUND:   if (t_q == 6'd63) state_d = UPDATE;
            UPDATE:  state_d = last_blk ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pad_q    <= '0;
            blk_q    <= '0;
            t_q      <= '0;
            hashed_q <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                hreg_q[i] <= '0;
                work_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pad_q <= pad;
                        blk_q <= '0;
                        for (int i = 0; i < 8; i++) hreg_q[i] <= H_INIT[i];
                    end
                end
                LOAD: begin
                    t_q <= '0;
                    for (int i = 0; i < 8; i++) work_q[i] <= hreg_q[i];
                end
                ROUND: begin
                    t_q       <= t_q + 6'd1;
                    work_q[0] <= t1 + t2;
                    work_q[1] <= work_q[0];
                    work_q[2] <= work_q[1];
                    work_q[3] <= work_q[2];
                    work_q[4] <= work_q[3] + t1;
                    work_q[5] <= work_q[4];
                    work_q[6] <= work_q[5];
                    work_q[7] <= work_q[6];
                end
                UPDATE: begin
                    for (int i = 0; i < 8; i++) hreg_q[i] <= hreg_q[i] + work_q[i];
                    if (!last_blk) begin
                        blk_q <= blk_q + 3'd1;
                        pad_q <= pad_q << 512;
                    end
                end
                DONE: begin
                    hashed_q <= {hreg_q[0], hreg_q[1], hreg_q[2], hreg_q[3],
                                 hreg_q[4], hreg_q[5], hreg_q[6], hreg_q[7]};
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign hashed = hashed_q;

endmodule
